// File: rtl/flooring_pkg.sv
// Shared constants and the floored-sample expansion function for the flooring datapath.
package flooring_pkg;

    // Widest datapath the expansion helper supports
    localparam int unsigned MAX_W = 64;

    localparam string FILL_ZERO = "ZERO";
    localparam string FILL_HALF = "HALF";

    // Re-expand a floored sample to dsize bits; returns {sat, data} with data right-aligned in MAX_W bits.
    // Width bookkeeping is done in 64-bit arithmetic so a shift by MAX_W yields an all-ones mask.
    function automatic logic [MAX_W:0] expand_floored(
        input logic [MAX_W-1:0] data,
        input int unsigned      dsize,
        input int unsigned      csize,
        input int unsigned      osize,
        input logic             fill_half,
        input logic             sat_decode
    );
        logic [MAX_W-1:0] omask;
        logic [MAX_W-1:0] dmask;
        logic [MAX_W-1:0] res;
        logic             sat;
        int unsigned      lsize;
        lsize = dsize - csize - osize;
        omask = (MAX_W'(1) << osize) - MAX_W'(1);
        dmask = (MAX_W'(1) << dsize) - MAX_W'(1);
        sat   = sat_decode && ((data & omask) == omask);
        res   = (data & omask) << lsize;
        if (fill_half && (lsize != 0)) begin
            res = res | (MAX_W'(1) << (lsize - 1));
        end
        if (sat) begin
            res = dmask;
        end
        return {sat, res & dmask};
    endfunction

endpackage

// File: rtl/flooring_restore_skid.sv
// Two-entry valid/ready skid FIFO; ready and valid come straight from registers.
module stream_skid2 #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         r_full;
    logic         r_nempty;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_nxt;

    assign w_push = in_valid & ~r_full;
    assign w_pop  = r_nempty & out_ready;

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
    end

    // Storage, pointers and registered full/not-empty flags
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_full   <= 1'b0;
            r_nempty <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == 2'd2);
            r_nempty <= (w_count_nxt != 2'd0);
        end
    end

    assign in_ready  = ~r_full;
    assign out_valid = r_nempty;
    assign out_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/flooring_restore.sv
// Re-expands floored samples to the wide datapath, decodes saturation markers and counts them.
module flooring_restore #(
    parameter int unsigned DSIZE      = 16,
    parameter int unsigned CSIZE      = 4,
    parameter int unsigned OSIZE      = 8,
    parameter string       FILL       = "ZERO",
    parameter string       SAT_DECODE = "TRUE",
    parameter string       SEQUENTIAL = "TRUE",
    parameter int unsigned CNTSIZE    = 16
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OSIZE-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DSIZE-1:0]   out_data,
    output logic               out_sat,
    input  logic               sat_clr,
    output logic [CNTSIZE-1:0] sat_count
);
    import flooring_pkg::*;

    localparam bit L_FILL_HALF = (FILL == FILL_HALF);
    localparam bit L_SAT_DEC   = (SAT_DECODE == "TRUE");

    if ((CSIZE >= DSIZE) || (OSIZE > DSIZE - CSIZE) || (DSIZE > MAX_W)) begin : g_param_err
        $error("flooring_restore: illegal DSIZE/CSIZE/OSIZE combination");
    end

    logic [DSIZE-1:0]   w_exp_data;
    logic               w_exp_sat;
    logic               w_sat_xfer;
    logic [CNTSIZE-1:0] r_sat_count;

    assign w_exp_data = DSIZE'(expand_floored(MAX_W'(in_data), DSIZE, CSIZE, OSIZE, L_FILL_HALF, L_SAT_DEC));
    assign w_exp_sat  = 1'(expand_floored(MAX_W'(in_data), DSIZE, CSIZE, OSIZE, L_FILL_HALF, L_SAT_DEC) >> MAX_W);

    if (SEQUENTIAL == "TRUE") begin : g_seq
        logic [DSIZE:0] w_skid_out;
        stream_skid2 #(.W(DSIZE + 1)) u_skid (
            .clock     (clock),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   ({w_exp_sat, w_exp_data}),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (w_skid_out)
        );
        assign out_data = w_skid_out[DSIZE-1:0];
        assign out_sat  = w_skid_out[DSIZE];
    end else if (SEQUENTIAL == "FALSE") begin : g_comb
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign out_data  = w_exp_data;
        assign out_sat   = w_exp_sat;
    end else begin : g_inert
        assign out_valid = 1'b0;
        assign in_ready  = 1'b0;
        assign out_data  = '0;
        assign out_sat   = 1'b0;
    end

    assign w_sat_xfer = out_valid & out_ready & out_sat;

    // Saturating count of transferred saturation beats; clear wins over increment
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (w_sat_xfer && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + CNTSIZE'(1);
        end
    end

    assign sat_count = r_sat_count;

endmodule

// File: tb/tb_flooring_restore.sv
// Directed bench for flooring_restore: default, half-fill/narrow-counter and combinational instances.
module tb_flooring_restore;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    // Instance A: defaults (ZERO fill, SAT decode, sequential, 16-bit counter)
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_sat, a_sat_clr = 1'b0;
    logic [7:0]  a_in_data = '0;
    logic [15:0] a_out_data, a_sat_count;

    // Instance H: HALF fill, SAT decode, 2-bit counter
    logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b0, h_out_sat, h_sat_clr = 1'b0;
    logic [7:0]  h_in_data = '0;
    logic [15:0] h_out_data;
    logic [1:0]  h_sat_count;

    // Instance F: combinational pass-through, no SAT decode
    logic        f_in_valid = 1'b0, f_in_ready, f_out_valid, f_out_ready = 1'b0, f_out_sat, f_sat_clr = 1'b0;
    logic [7:0]  f_in_data = '0;
    logic [15:0] f_out_data, f_sat_count;

    flooring_restore u_dut_a (
        .clock(clock), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_sat(a_out_sat),
        .sat_clr(a_sat_clr), .sat_count(a_sat_count));

    flooring_restore #(.FILL("HALF"), .CNTSIZE(2)) u_dut_h (
        .clock(clock), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data), .out_sat(h_out_sat),
        .sat_clr(h_sat_clr), .sat_count(h_sat_count));

    flooring_restore #(.SAT_DECODE("FALSE"), .SEQUENTIAL("FALSE")) u_dut_f (
        .clock(clock), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data), .out_sat(f_out_sat),
        .sat_clr(f_sat_clr), .sat_count(f_sat_count));

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else n_pass++;
        n_total++; if (a_out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", a_out_data); else n_pass++;
        n_total++; if (a_out_sat !== 1'b0) $display("FAIL reset_out_sat got %b want 0", a_out_sat); else n_pass++;
        n_total++; if (a_sat_count !== 16'h0000) $display("FAIL reset_sat_count got %h want 0000", a_sat_count); else n_pass++;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a_in_ready); else n_pass++;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_fill();
        a_out_ready = 1'b1;
        @(negedge clock);
        a_in_valid = 1'b1; a_in_data = 8'h5A;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL zero_no_bypass got %b want 0", a_out_valid); else n_pass++;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        n_total++; if (a_out_valid !== 1'b1) $display("FAIL zero_latency got %b want 1", a_out_valid); else n_pass++;
        n_total++; if (a_out_data !== 16'h05A0) $display("FAIL zero_data got %h want 05a0", a_out_data); else n_pass++;
        n_total++; if (a_out_sat !== 1'b0) $display("FAIL zero_sat got %b want 0", a_out_sat); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL zero_drained got %b want 0", a_out_valid); else n_pass++;
    endtask

    task automatic test_sat_decode();
        @(negedge clock);
        a_in_valid = 1'b1; a_in_data = 8'hFF;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        n_total++; if (a_out_data !== 16'hFFFF) $display("FAIL satdec_data got %h want ffff", a_out_data); else n_pass++;
        n_total++; if (a_out_sat !== 1'b1) $display("FAIL satdec_sat got %b want 1", a_out_sat); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (a_sat_count !== 16'd1) $display("FAIL satdec_count got %0d want 1", a_sat_count); else n_pass++;
    endtask

    task automatic test_half_fill();
        h_out_ready = 1'b1;
        @(negedge clock);
        h_in_valid = 1'b1; h_in_data = 8'h5A;
        @(posedge clock); #1;
        h_in_data = 8'h00;
        n_total++; if (h_out_data !== 16'h05A8) $display("FAIL half_5a got %h want 05a8", h_out_data); else n_pass++;
        @(posedge clock); #1;
        h_in_valid = 1'b0;
        n_total++; if (h_out_valid !== 1'b1) $display("FAIL half_b2b_valid got %b want 1", h_out_valid); else n_pass++;
        n_total++; if (h_out_data !== 16'h0008) $display("FAIL half_00 got %h want 0008", h_out_data); else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic test_plain_expand();
        f_out_ready = 1'b1; f_in_valid = 1'b1; f_in_data = 8'hFF;
        #1;
        n_total++; if (f_out_valid !== 1'b1) $display("FAIL comb_valid got %b want 1", f_out_valid); else n_pass++;
        n_total++; if (f_out_data !== 16'h0FF0) $display("FAIL comb_plain_ff got %h want 0ff0", f_out_data); else n_pass++;
        n_total++; if (f_out_sat !== 1'b0) $display("FAIL comb_sat got %b want 0", f_out_sat); else n_pass++;
        f_out_ready = 1'b0; f_in_data = 8'h5A;
        #1;
        n_total++; if (f_in_ready !== 1'b0) $display("FAIL comb_ready got %b want 0", f_in_ready); else n_pass++;
        n_total++; if (f_out_data !== 16'h05A0) $display("FAIL comb_5a got %h want 05a0", f_out_data); else n_pass++;
        f_in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b0;
        @(negedge clock);
        a_in_valid = 1'b1; a_in_data = 8'h11;
        @(posedge clock); #1;
        a_in_data = 8'h22;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", a_in_ready); else n_pass++;
        @(posedge clock); #1;
        a_in_data = 8'h33;
        n_total++; if (a_in_ready !== 1'b0) $display("FAIL bp_full got %b want 0", a_in_ready); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (a_in_ready !== 1'b0) $display("FAIL bp_full_hold got %b want 0", a_in_ready); else n_pass++;
        n_total++; if (a_out_data !== 16'h0110) $display("FAIL bp_stable got %h want 0110", a_out_data); else n_pass++;
        a_out_ready = 1'b1;
        @(posedge clock); #1;
        n_total++; if (a_out_data !== 16'h0220) $display("FAIL bp_second got %h want 0220", a_out_data); else n_pass++;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        n_total++; if (a_out_data !== 16'h0330) $display("FAIL bp_third got %h want 0330", a_out_data); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", a_out_valid); else n_pass++;
    endtask

    task automatic test_sat_count();
        h_out_ready = 1'b1;
        @(negedge clock);
        h_in_valid = 1'b1; h_in_data = 8'hFF;
        repeat (5) @(posedge clock);
        #1;
        h_in_valid = 1'b0;
        n_total++; if (h_out_data !== 16'hFFFF) $display("FAIL cnt_sat_data got %h want ffff", h_out_data); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (h_sat_count !== 2'd3) $display("FAIL cnt_saturate got %0d want 3", h_sat_count); else n_pass++;
    endtask

    task automatic test_sat_clr();
        @(negedge clock);
        h_in_valid = 1'b1; h_in_data = 8'hFF;
        @(posedge clock); #1;
        h_in_valid = 1'b0; h_sat_clr = 1'b1;
        n_total++; if (h_out_sat !== 1'b1) $display("FAIL clr_beat_sat got %b want 1", h_out_sat); else n_pass++;
        @(posedge clock); #1;
        h_sat_clr = 1'b0;
        n_total++; if (h_sat_count !== 2'd0) $display("FAIL clr_priority got %0d want 0", h_sat_count); else n_pass++;
        h_in_valid = 1'b1;
        @(posedge clock); #1;
        h_in_valid = 1'b0;
        @(posedge clock); #1;
        n_total++; if (h_sat_count !== 2'd1) $display("FAIL clr_recount got %0d want 1", h_sat_count); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        a_out_ready = 1'b0;
        @(negedge clock);
        a_in_valid = 1'b1; a_in_data = 8'h44;
        @(posedge clock); #1;
        a_in_data = 8'h55;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        n_total++; if (a_out_valid !== 1'b1) $display("FAIL mid_buffered got %b want 1", a_out_valid); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL mid_valid_drop got %b want 0", a_out_valid); else n_pass++;
        n_total++; if (a_out_data !== 16'h0000) $display("FAIL mid_data_clear got %h want 0000", a_out_data); else n_pass++;
        @(negedge clock);
        rst_n = 1'b1; a_out_ready = 1'b1;
        #1;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", a_in_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            n_total++; if (a_out_valid !== 1'b0) $display("FAIL mid_no_stale[%0d] got %b want 0", i, a_out_valid); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_sat_decode();
        test_half_fill();
        test_plain_expand();
        test_back_to_back();
        test_sat_count();
        test_sat_clr();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
